// File: rtl/spi_reg_writer_if.sv
// Request and SPI pin bundle for spi_reg_writer.
//   master : request source (drives req_valid/rw/addr/data, observes the rest)
//   slave  : spi_reg_writer (drives req_ready, sclk, cs, mosi, busy, done)
interface spi_reg_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, sclk, cs, mosi, busy, done
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, sclk, cs, mosi, busy, done
  );
endinterface

// File: rtl/spi_reg_writer.sv
// SPI mode-0 master that writes one 16-bit frame {rw, addr[6:0], data[7:0]},
// MSB first, per accepted request.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of spi_reg_writer_if
//                req_valid/req_ready/req_rw/req_addr/req_data - request handshake
//                sclk/cs/mosi - SPI pins; busy - frame plus gap in progress;
//                done - one-cycle pulse on the first cs-high cycle after a frame
module spi_reg_writer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_reg_writer_if.slave   bus
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BIT_W      = 5;
  localparam int unsigned MAX_AB     = (CLK_DIV > SETUP_CYCLES) ? CLK_DIV : SETUP_CYCLES;
  localparam int unsigned MAX_CYC    = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HIGH,
    SCLK_LOW,
    GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_q, cs_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; cnt counts cycles spent in the current phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          shreg_d  = {bus.req_rw, bus.req_addr, bus.req_data};
          bitcnt_d = '0;
          cs_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        bitcnt_d = '0;
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SCLK_HIGH;
        end
      end

      SCLK_HIGH: begin
        // Shift on the falling edge so mosi is stable across the whole high phase;
        // zeros shifted in leave mosi low after the last bit.
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d    = '0;
          sclk_d   = 1'b0;
          shreg_d  = {shreg_q[FRAME_BITS-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          state_d  = SCLK_LOW;
        end
      end

      SCLK_LOW: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bitcnt_q == BIT_W'(FRAME_BITS)) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            sclk_d  = 1'b1;
            state_d = SCLK_HIGH;
          end
        end
      end

      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // mosi is the shift register MSB, so it is registered and reads 0 whenever shreg is empty
  assign bus.req_ready = (state_q == IDLE);
  assign bus.sclk      = sclk_q;
  assign bus.cs        = cs_q;
  assign bus.mosi      = shreg_q[FRAME_BITS-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer: directed vector table, multi-cycle
// corner sequences and randomized writes against a behavioural peripheral.
module tb_spi_reg_writer;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned SETUP_CYCLES = 4;
  localparam int unsigned GAP_CYCLES   = 8;
  localparam int unsigned FRAME_LOW    = SETUP_CYCLES + 32 * CLK_DIV;
  localparam int          TMO          = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_reg_writer_if bus ();

  spi_reg_writer #(
    .CLK_DIV      (CLK_DIV),
    .SETUP_CYCLES (SETUP_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  // ---------------- peripheral / line monitor ----------------
  typedef struct {
    logic [15:0] bits;
    int          edges;
    int          low;
  } frame_t;

  frame_t      frames[$];
  logic [7:0]  periph[5];
  logic [7:0]  exp_regs[5];
  logic [15:0] cap = '0;
  int edges = 0, low = 0, high_run = 0, last_gap = -1;
  int done_cnt = 0, mosi_viol = 0, ready_viol = 0, done_viol = 0, idle_viol = 0;
  int trk_cnt = 0, busy_lat = -1, idx;
  bit trk = 1'b0, rise;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

  always @(negedge clk) begin
    rise = bus.cs && !p_cs;
    if (!bus.cs) begin
      if (p_cs) begin
        cap = '0; edges = 0; low = 0; last_gap = high_run;
      end
      low++;
      if (bus.sclk && !p_sclk) begin
        cap = {cap[14:0], bus.mosi};
        edges++;
      end
      if (!p_cs && (bus.mosi !== p_mosi) && !(p_sclk && !bus.sclk)) mosi_viol++;
    end else begin
      if (bus.sclk || bus.mosi) idle_viol++;
    end
    if (rise) begin
      frames.push_back('{cap, edges, low});
      idx = int'(cap[14:8]);
      if (edges == 16 && cap[15] && idx < 5) periph[idx] = cap[7:0];
      high_run = 0; trk = 1'b1; trk_cnt = 0; busy_lat = -1;
    end else if (trk) begin
      trk_cnt++;
      if (!bus.busy) begin busy_lat = trk_cnt; trk = 1'b0; end
    end
    if (bus.cs) high_run++;
    if (bus.done) begin
      done_cnt++;
      if (!rise) done_viol++;
    end
    if (bus.req_ready == bus.busy) ready_viol++;
    p_cs = bus.cs; p_sclk = bus.sclk; p_mosi = bus.mosi;
  end

  // ---------------- driver helpers ----------------
  task automatic do_write(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a; bus.req_data = d;
    while (!bus.req_ready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) tmo_fail("accept");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) tmo_fail({name, "_idle"});
    @(posedge clk); #1;
  endtask

  task automatic check_txn(input string name, input logic [15:0] exp_bits, input int done0);
    frame_t f;
    chk({name, "_nframes"}, frames.size(), 1);
    if (frames.size() > 0) begin
      f = frames.pop_front();
      chk({name, "_bits"}, f.bits, exp_bits);
      chk({name, "_edges"}, f.edges, 16);
      chk({name, "_cs_low"}, f.low, FRAME_LOW);
    end
    chk({name, "_done"}, done_cnt - done0, 1);
    chk({name, "_busy_lat"}, busy_lat, GAP_CYCLES);
    frames.delete();
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_reg%0d", name, i + 1), periph[i], exp_regs[i]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic [15:0] frame;
    int         reg_idx;   // register written, -1 when the peripheral ignores it
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, rdy_bad;
    logic rw;
    logic [6:0] a;
    logic [7:0] d;
    logic [15:0] ef;

    vecs[0] = '{1'b1, 7'd0,   8'hA5, 16'h80A5,  0};
    vecs[1] = '{1'b1, 7'd2,   8'h3C, 16'h823C,  2};
    vecs[2] = '{1'b1, 7'd4,   8'hFF, 16'h84FF,  4};
    vecs[3] = '{1'b0, 7'd1,   8'h99, 16'h0199, -1};
    vecs[4] = '{1'b1, 7'd7,   8'h55, 16'h8755, -1};
    vecs[5] = '{1'b1, 7'd5,   8'hC3, 16'h85C3, -1};
    vecs[6] = '{1'b1, 7'd127, 8'h00, 16'hFF00, -1};
    vecs[7] = '{1'b0, 7'd0,   8'hFF, 16'h00FF, -1};
    for (int i = 0; i < 5; i++) begin periph[i] = '0; exp_regs[i] = '0; end

    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs", bus.cs, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.req_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: single writes, frame content/timing and register effect
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      do_write(vecs[i].rw, vecs[i].addr, vecs[i].data);
      wait_idle($sformatf("vec%0d", i));
      check_txn($sformatf("vec%0d", i), vecs[i].frame, d0);
      if (vecs[i].reg_idx >= 0) exp_regs[vecs[i].reg_idx] = vecs[i].data;
      check_regs($sformatf("vec%0d", i));
    end

    // Back-to-back with req_valid held high
    frames.delete();
    d0 = done_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 7'd1; bus.req_data = 8'h11;
    n = 0;
    while (!bus.req_ready && n < TMO) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_addr = 7'd3; bus.req_data = 8'h33;
    n = 0;
    while (n < TMO) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
    end
    if (n >= TMO) tmo_fail("b2b_second");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("b2b_f0", frames[0].bits, 16'h8111);
      chk("b2b_f1", frames[1].bits, 16'h8333);
    end
    chk("b2b_gap", last_gap, GAP_CYCLES + 1);
    chk("b2b_done", done_cnt - d0, 2);
    frames.delete();
    exp_regs[1] = 8'h11; exp_regs[3] = 8'h33;
    check_regs("b2b");

    // Inputs churn while busy
    d0 = done_cnt;
    do_write(1'b1, 7'd3, 8'h5A);
    n = 0; rdy_bad = 0;
    while (bus.busy && n < TMO) begin
      @(negedge clk);
      if (bus.busy && bus.req_ready) rdy_bad++;
      bus.req_rw = 1'($urandom); bus.req_addr = 7'($urandom); bus.req_data = 8'($urandom);
      n++;
    end
    if (n >= TMO) tmo_fail("churn_idle");
    @(posedge clk); #1;
    chk("churn_ready_low", rdy_bad, 0);
    check_txn("churn", 16'h835A, d0);
    exp_regs[3] = 8'h5A;
    check_regs("churn");

    // Reset after the 5th rising edge
    d0 = done_cnt;
    do_write(1'b1, 7'd0, 8'h77);
    n = 0;
    while (edges != 5 && n < TMO) begin @(posedge clk); n++; end
    if (n >= TMO) tmo_fail("abort_edges");
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs", bus.cs, 1);
    chk("abort_sclk", bus.sclk, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    chk("abort_nframes", frames.size(), 1);
    if (frames.size() > 0) chk("abort_edges", frames[0].edges, 5);
    chk("abort_done", done_cnt - d0, 0);
    frames.delete();
    check_regs("abort");
    d0 = done_cnt;
    do_write(1'b1, 7'd0, 8'h42);
    wait_idle("after_abort");
    check_txn("after_abort", 16'h8042, d0);
    exp_regs[0] = 8'h42;
    check_regs("after_abort");

    // Randomized writes against the reference rules
    for (int i = 0; i < 24; i++) begin
      rw = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      d  = 8'($urandom);
      ef = 16'(int'(rw) * 32768 + int'(a) * 256 + int'(d));
      d0 = done_cnt;
      do_write(rw, a, d);
      wait_idle($sformatf("rnd%0d", i));
      check_txn($sformatf("rnd%0d", i), ef, d0);
      if (rw && a < 7'd5) exp_regs[int'(a)] = d;
    end
    check_regs("rnd");

    chk("mosi_stable", mosi_viol, 0);
    chk("ready_decode", ready_viol, 0);
    chk("done_placement", done_viol, 0);
    chk("idle_lines", idle_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_writer.md
Name: spi_reg_writer

Overview:
SPI controller that writes the target's 8-bit register bank. It is the transmitting end of the existing 16-bit register-write SPI link. It accepts one write request at a time on a valid/ready interface, then serialises it as a 16-bit frame {rw, addr[6:0], data[7:0]}, MSB first, driving sclk, cs and mosi. It sits on the host/test side, or in a loopback harness directly against the SPI peripheral.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255. The peripheral's 2-flop synchroniser requires each sclk level to last at least 2 clk.
SETUP_CYCLES, 4, clk cycles from cs falling to the first sclk rising edge; minimum 1.
GAP_CYCLES, 8, minimum clk cycles cs is held high after a frame before the next request is accepted; minimum 4.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  write request present
req_ready  out  1  block can accept a request this cycle
req_rw  in  1  frame bit 15 (1 = write; 0 frames are sent but the peripheral discards them)
req_addr  in  7  register address, frame bits 14:8
req_data  in  8  register data, frame bits 7:0
sclk  out  1  SPI clock, idle low (mode 0)
cs  out  1  chip select, active low, idle high
mosi  out  1  serial data to peripheral
busy  out  1  high from request acceptance until the end of the gap
done  out  1  one-cycle pulse in the first cycle cs is high after a completed frame

Behaviour:
- All outputs are registered, with no combinational input-to-output paths except req_ready, which is a state decode.
- Reset (async, rst_n low): state IDLE, sclk=0, cs=1, mosi=0, busy=0, done=0, req_ready=1, shift register=0, all counters=0.
- States: IDLE, SETUP, SCLK_HIGH, SCLK_LOW, GAP.
- IDLE:
  - req_ready=1.
  - On the edge where req_valid&&req_ready: latch shreg={req_rw,req_addr,req_data}; next cycle cs=0, mosi=shreg[15], busy=1, req_ready=0; go to SETUP.
- SETUP:
  - sclk=0 for SETUP_CYCLES cycles, then go to SCLK_HIGH with sclk=1.
  - bitcnt=0.
- SCLK_HIGH:
  - sclk=1 for CLK_DIV cycles; mosi is held stable for the whole high phase.
  - Then go to SCLK_LOW with sclk=0.
  - On that falling transition mosi updates to the next bit (shreg shifts left); after bit 0 it updates to 0.
- SCLK_LOW:
  - sclk=0 for CLK_DIV cycles; bitcnt increments on entry.
  - If bitcnt<16, go to SCLK_HIGH.
  - If bitcnt==16 at the end of the phase: cs=1, done=1 for one cycle; go to GAP.
- GAP:
  - cs=1, sclk=0, mosi=0 for GAP_CYCLES cycles, then IDLE, busy=0, req_ready=1.
- Frame timing:
  - exactly 16 sclk rising edges per frame.
  - cs low for SETUP_CYCLES + 32*CLK_DIV cycles.
  - mosi is stable from at least CLK_DIV cycles before each rising edge until CLK_DIV cycles after it.
  - minimum cs-high time between frames is GAP_CYCLES+1 cycles.
- Requests are not queued. Request inputs are sampled only on the accept edge; changes while busy have no effect on the frame in flight.
- req_valid held continuously produces back-to-back frames separated by exactly GAP_CYCLES+1 cs-high cycles.
- Reset mid-frame: cs returns high asynchronously with sclk=0. No done pulse. The partial frame (<16 edges) is discarded by the peripheral.
- The block performs no address-range check. Addresses >=5 are transmitted; the peripheral ignores them.
- sdo from the peripheral is not used (write-only link).

Test Plan:
1. CLK_DIV=4, SETUP=4, GAP=8; write rw=1 addr=0 data=0xA5 -> mosi captured at the 16 sclk rising edges = 0x80A5; cs low for exactly 132 cycles; exactly one done pulse; busy deasserts 8 cycles after cs rises.
2. Loopback to the SPI peripheral: write addr=2 data=0x3C, then addr=4 data=0xFF -> reg3=0x3C, reg5=0xFF; reg1, reg2 and reg4 remain 0x00.
3. req_valid held high with two queued values (addr 1=0x11, addr 3=0x33) -> two frames, cs high exactly 9 cycles between them, reg2=0x11, reg4=0x33, two done pulses.
4. Change req_addr/req_data every cycle while busy -> the transmitted frame matches the value latched at acceptance; req_ready stays 0 throughout.
5. Assert rst_n low after the 5th rising edge of a write addr=0 data=0x77 -> cs=1 and sclk=0 immediately, no done, reg1 unchanged; a following write addr=0 data=0x42 gives reg1=0x42.
6. rw=0 addr=1 data=0x99, then rw=1 addr=7 data=0x55 -> both frames complete with done pulses; all peripheral registers are unchanged.
